// File: rtl/rf_wb_sched.sv
// Register-file write-port scheduler: per-register busy scoreboard with issue hazard
// stall, plus round-robin arbitration of two writeback sources into a registered write port.
module rf_wb_sched #(
  parameter int RF_SIZE_LOG = 2,
  parameter int REG_LEN     = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          issue_valid,
  output logic                          issue_ready,
  input  logic                          issue_wen,
  input  logic [RF_SIZE_LOG-1:0]        issue_rd,
  input  logic                          issue_use1,
  input  logic [RF_SIZE_LOG-1:0]        issue_rs1,
  input  logic                          issue_use2,
  input  logic [RF_SIZE_LOG-1:0]        issue_rs2,
  input  logic                          wb0_valid,
  output logic                          wb0_ready,
  input  logic [RF_SIZE_LOG-1:0]        wb0_rd,
  input  logic [REG_LEN-1:0]            wb0_data,
  input  logic                          wb1_valid,
  output logic                          wb1_ready,
  input  logic [RF_SIZE_LOG-1:0]        wb1_rd,
  input  logic [REG_LEN-1:0]            wb1_data,
  output logic                          rf_wen,
  output logic [RF_SIZE_LOG-1:0]        rf_rd,
  output logic [REG_LEN-1:0]            rf_rd_data,
  output logic [(1<<RF_SIZE_LOG)-1:0]   busy,
  output logic                          err
);

  localparam int RF_SIZE = 1 << RF_SIZE_LOG;

  logic [RF_SIZE-1:0]     busy_q, busy_d;
  logic                   rf_wen_q, rf_wen_d;
  logic [RF_SIZE_LOG-1:0] rf_rd_q, rf_rd_d;
  logic [REG_LEN-1:0]     rf_data_q, rf_data_d;
  logic                   rr_last_q, rr_last_d;
  logic                   err_q, err_d;

  logic                   hz;
  logic                   xfer;
  logic                   issue_set;
  logic [RF_SIZE_LOG-1:0] wr_rd;
  logic [REG_LEN-1:0]     wr_data;

  always_comb begin
    hz = (issue_wen  & busy_q[issue_rd])
       | (issue_use1 & busy_q[issue_rs1])
       | (issue_use2 & busy_q[issue_rs2]);
    issue_ready = !hz;
    issue_set   = issue_valid & issue_ready & issue_wen;

    // rr_last_q=1 means wb1 won last, so wb0 takes the next tie
    wb0_ready = rst_n & wb0_valid & (!wb1_valid | rr_last_q);
    wb1_ready = rst_n & wb1_valid & (!wb0_valid | !rr_last_q);
    xfer      = wb0_ready | wb1_ready;
    wr_rd     = wb1_ready ? wb1_rd   : wb0_rd;
    wr_data   = wb1_ready ? wb1_data : wb0_data;

    rf_wen_d  = xfer;
    rf_rd_d   = xfer ? wr_rd   : rf_rd_q;
    rf_data_d = xfer ? wr_data : rf_data_q;
    rr_last_d = xfer ? wb1_ready : rr_last_q;

    // clear at commit first so a simultaneous set of the same register wins
    busy_d = busy_q;
    if (rf_wen_q)  busy_d[rf_rd_q]  = 1'b0;
    if (issue_set) busy_d[issue_rd] = 1'b1;

    err_d = err_q
          | (xfer & !busy_q[wr_rd])
          | (wb0_valid & wb1_valid & (wb0_rd == wb1_rd))
          | (issue_set & rf_wen_q & (issue_rd == rf_rd_q));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q    <= '0;
      rf_wen_q  <= 1'b0;
      rf_rd_q   <= '0;
      rf_data_q <= '0;
      rr_last_q <= 1'b1;
      err_q     <= 1'b0;
    end else begin
      busy_q    <= busy_d;
      rf_wen_q  <= rf_wen_d;
      rf_rd_q   <= rf_rd_d;
      rf_data_q <= rf_data_d;
      rr_last_q <= rr_last_d;
      err_q     <= err_d;
    end
  end

  assign rf_wen     = rf_wen_q;
  assign rf_rd      = rf_rd_q;
  assign rf_rd_data = rf_data_q;
  assign busy       = busy_q;
  assign err        = err_q;

endmodule

// File: tb/tb_rf_wb_sched.sv
// Self-checking bench for rf_wb_sched: hazard vector table plus cycle-stepped
// sequences checked against a reference model with a writeback scoreboard queue.
module tb_rf_wb_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       issue_valid, issue_ready, issue_wen, issue_use1, issue_use2;
  logic [1:0] issue_rd, issue_rs1, issue_rs2;
  logic       wb0_valid, wb0_ready, wb1_valid, wb1_ready;
  logic [1:0] wb0_rd, wb1_rd;
  logic [3:0] wb0_data, wb1_data;
  logic       rf_wen;
  logic [1:0] rf_rd;
  logic [3:0] rf_rd_data;
  logic [3:0] busy;
  logic       err;

  always #5 clk = ~clk;

  rf_wb_sched #(.RF_SIZE_LOG(2), .REG_LEN(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_wen(issue_wen),
    .issue_rd(issue_rd), .issue_use1(issue_use1), .issue_rs1(issue_rs1),
    .issue_use2(issue_use2), .issue_rs2(issue_rs2),
    .wb0_valid(wb0_valid), .wb0_ready(wb0_ready), .wb0_rd(wb0_rd), .wb0_data(wb0_data),
    .wb1_valid(wb1_valid), .wb1_ready(wb1_ready), .wb1_rd(wb1_rd), .wb1_data(wb1_data),
    .rf_wen(rf_wen), .rf_rd(rf_rd), .rf_rd_data(rf_rd_data), .busy(busy), .err(err)
  );

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  logic [3:0] m_busy;
  logic       m_rr, m_rfwen, m_err;
  logic [1:0] m_rfrd;
  logic [5:0] sb_q[$];

  typedef struct {
    logic       wen;
    logic [1:0] rd;
    logic       u1;
    logic [1:0] rs1;
    logic       u2;
    logic [1:0] rs2;
    logic       exp_ready;
  } hz_vec_t;
  hz_vec_t hz_tab[8];

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_idle();
    issue_valid = 0; issue_wen = 0; issue_rd = 0; issue_use1 = 0; issue_rs1 = 0;
    issue_use2 = 0; issue_rs2 = 0;
    wb0_valid = 0; wb0_rd = 0; wb0_data = 0; wb1_valid = 0; wb1_rd = 0; wb1_data = 0;
  endtask

  task automatic model_reset();
    m_busy = '0; m_rr = 1'b1; m_rfwen = 1'b0; m_rfrd = '0; m_err = 1'b0;
    sb_q.delete();
  endtask

  // reset with live requests on the inputs; readies must be low throughout
  task automatic do_reset();
    @(negedge clk);
    issue_valid = 1; issue_wen = 1; issue_rd = 2;
    wb0_valid = 1; wb0_rd = 1; wb0_data = 4'h5;
    #2 rst_n = 0;
    model_reset();
    #1;
    chk("rst_rf_wen", rf_wen, 0);
    chk("rst_rf_rd", rf_rd, 0);
    chk("rst_rf_data", rf_rd_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_wb0_ready", wb0_ready, 0);
    @(posedge clk); #1;
    chk("rst_hold_busy", busy, 0);
    chk("rst_hold_wb0_ready", wb0_ready, 0);
    @(negedge clk);
    drive_idle();
    #2 rst_n = 1;
    #1;
    chk("post_rst_issue_ready", issue_ready, 1);
    chk("post_rst_busy", busy, 0);
  endtask

  // one clock cycle: drive at negedge, check combinational outputs, then registered ones
  task automatic step(input logic iv, input logic iwen, input logic [1:0] ird,
                      input logic iu1, input logic [1:0] irs1,
                      input logic iu2, input logic [1:0] irs2,
                      input logic v0, input logic [1:0] rd0, input logic [3:0] d0,
                      input logic v1, input logic [1:0] rd1, input logic [3:0] d1);
    logic hz, g0, g1, set;
    logic [5:0] e;
    @(negedge clk);
    issue_valid = iv; issue_wen = iwen; issue_rd = ird; issue_use1 = iu1; issue_rs1 = irs1;
    issue_use2 = iu2; issue_rs2 = irs2;
    wb0_valid = v0; wb0_rd = rd0; wb0_data = d0; wb1_valid = v1; wb1_rd = rd1; wb1_data = d1;
    #1;
    hz = (iwen & m_busy[ird]) | (iu1 & m_busy[irs1]) | (iu2 & m_busy[irs2]);
    g0 = v0 & (!v1 | m_rr);
    g1 = v1 & (!v0 | !m_rr);
    chk("issue_ready", issue_ready, !hz);
    chk("wb0_ready", wb0_ready, g0);
    chk("wb1_ready", wb1_ready, g1);
    set = iv & !hz & iwen;
    if ((g0 & !m_busy[rd0]) | (g1 & !m_busy[rd1]) | (v0 & v1 & (rd0 == rd1)) |
        (set & m_rfwen & (ird == m_rfrd)))
      m_err = 1'b1;
    if (m_rfwen) m_busy[m_rfrd] = 1'b0;
    if (set) m_busy[ird] = 1'b1;
    if (g0 | g1) begin
      sb_q.push_back(g1 ? {rd1, d1} : {rd0, d0});
      m_rr = g1;
      m_rfwen = 1'b1;
      m_rfrd = g1 ? rd1 : rd0;
    end else begin
      m_rfwen = 1'b0;
    end
    @(posedge clk); #1;
    chk("rf_wen", rf_wen, m_rfwen);
    if (m_rfwen) begin
      if (sb_q.size() == 0) begin
        chk("scoreboard_empty", 1, 0);
      end else begin
        e = sb_q.pop_front();
        chk("rf_rd", rf_rd, e[5:4]);
        chk("rf_rd_data", rf_rd_data, e[3:0]);
      end
    end
    chk("busy", busy, m_busy);
    chk("err", err, m_err);
  endtask

  task automatic idle();
    step(0,0,0, 0,0, 0,0, 0,0,0, 0,0,0);
  endtask

  task automatic issue(input logic [1:0] rd);
    step(1,1,rd, 0,0, 0,0, 0,0,0, 0,0,0);
  endtask

  task automatic wb(input logic sel, input logic [1:0] rd, input logic [3:0] d);
    if (!sel) step(0,0,0, 0,0, 0,0, 1,rd,d, 0,0,0);
    else      step(0,0,0, 0,0, 0,0, 0,0,0, 1,rd,d);
  endtask

  initial begin
    // busy = 4'b1010 when this table is applied
    hz_tab[0] = '{1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1};
    hz_tab[1] = '{1'b1, 2'd1, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0};
    hz_tab[2] = '{1'b0, 2'd0, 1'b1, 2'd3, 1'b0, 2'd0, 1'b0};
    hz_tab[3] = '{1'b0, 2'd0, 1'b1, 2'd2, 1'b0, 2'd0, 1'b1};
    hz_tab[4] = '{1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 2'd1, 1'b0};
    hz_tab[5] = '{1'b0, 2'd1, 1'b0, 2'd1, 1'b0, 2'd3, 1'b1};
    hz_tab[6] = '{1'b1, 2'd2, 1'b1, 2'd0, 1'b1, 2'd2, 1'b1};
    hz_tab[7] = '{1'b1, 2'd3, 1'b0, 2'd2, 1'b0, 2'd0, 1'b0};

    rst_n = 1;
    drive_idle();
    model_reset();

    // reset behaviour with live requests
    do_reset();

    // hazard table
    issue(2'd1);
    issue(2'd3);
    @(negedge clk);
    for (int unsigned i = 0; i < 8; i++) begin
      issue_valid = 0;
      issue_wen = hz_tab[i].wen; issue_rd = hz_tab[i].rd;
      issue_use1 = hz_tab[i].u1; issue_rs1 = hz_tab[i].rs1;
      issue_use2 = hz_tab[i].u2; issue_rs2 = hz_tab[i].rs2;
      #1;
      chk("hz_table", issue_ready, hz_tab[i].exp_ready);
    end
    drive_idle();
    do_reset();

    // issue rd=2, writeback via wb0, busy cleared the cycle after commit
    issue(2'd2);
    idle();
    wb(0, 2'd2, 4'hA);
    idle();
    idle();

    // RAW on rs1=1 stalls until commit edge
    issue(2'd1);
    step(1,0,0, 1,2'd1, 0,0, 1,2'd1,4'h5, 0,0,0);
    step(1,0,0, 1,2'd1, 0,0, 0,0,0, 0,0,0);
    step(1,0,0, 1,2'd1, 0,0, 0,0,0, 0,0,0);
    // WAW on rd=1
    issue(2'd1);
    step(1,1,2'd1, 0,0, 0,0, 0,0,0, 1,2'd1,4'h7);
    step(1,1,2'd1, 0,0, 0,0, 0,0,0, 0,0,0);
    step(1,1,2'd1, 0,0, 0,0, 0,0,0, 0,0,0);
    wb(0, 2'd1, 4'h9);
    idle();
    idle();

    // contention from reset: wb0 first, then alternating
    do_reset();
    for (int unsigned i = 0; i < 4; i++)
      step(0,0,0, 0,0, 0,0, 1,2'd0,4'h1, 1,2'd3,4'hC);
    idle();

    // error on writeback to a non-busy reg, sticky, cleared by mid-stream reset
    do_reset();
    wb(1, 2'd3, 4'h6);
    idle();
    issue(2'd0);
    wb(0, 2'd0, 4'h2);
    idle();
    issue(2'd2);
    issue(2'd1);
    step(0,0,0, 0,0, 0,0, 1,2'd2,4'h3, 1,2'd1,4'h4);
    do_reset();
    idle();

    // same-rd on both sources flags error
    issue(2'd2);
    step(0,0,0, 0,0, 0,0, 1,2'd2,4'hE, 1,2'd2,4'hF);
    idle();
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
